// File: rtl/timer_ctrl.sv
// Bus-side controller for a 16-bit reloading timer: register file,
// load/run sequencing, sticky expiry status and maskable interrupt.
module timer_ctrl #(
  parameter int timerwid = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bus_cs,
  input  logic                bus_wr,
  input  logic                bus_rd,
  input  logic [1:0]          bus_addr,
  input  logic [timerwid-1:0] bus_wdata,
  output logic [timerwid-1:0] bus_rdata,
  output logic                bus_rvalid,
  output logic                bus_busy,
  output logic                irq,
  output logic                tmr_cs,
  output logic                tmr_wr,
  output logic                tmr_start,
  output logic                tmr_rd,
  output logic [timerwid-1:0] tmr_datain,
  input  logic                tmr_intrup,
  input  logic [timerwid-1:0] tmr_dataout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_RELOAD = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  state_t              state_q, state_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [timerwid-1:0] reload_q, reload_d;
  logic                expired_q, expired_d;
  logic                intr_q, intr_d;
  logic                irq_q, irq_d;
  logic                rd1_q, rd1_d;
  logic                rd2_q, rd2_d;
  logic                rvalid_q, rvalid_d;
  logic [timerwid-1:0] rdata_q, rdata_d;

  logic                wr_en;
  logic                rd_req;
  logic                evt;

  always_comb begin
    wr_en     = bus_cs & bus_wr;
    rd_req    = bus_cs & bus_rd & ~bus_wr & ~(rd1_q | rd2_q);
    evt       = tmr_intrup & ~intr_q;
    ctrl_d    = ctrl_q;
    reload_d  = reload_q;
    expired_d = expired_q;
    intr_d    = tmr_intrup;
    irq_d     = expired_q & ctrl_q[2];
    rd1_d     = 1'b0;
    rd2_d     = rd1_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    state_d   = state_q;

    if (wr_en) begin
      unique case (bus_addr)
        A_CTRL:   ctrl_d = bus_wdata[2:0];
        A_RELOAD: reload_d = bus_wdata;
        A_STATUS: if (bus_wdata[0]) expired_d = 1'b0;
        default:  ;
      endcase
    end
    // a new expiry outranks a same-cycle clear
    if (evt) expired_d = 1'b1;

    if (rd_req) begin
      unique case (bus_addr)
        A_CTRL: begin
          rvalid_d = 1'b1;
          rdata_d  = {{(timerwid-3){1'b0}}, ctrl_q};
        end
        A_RELOAD: begin
          rvalid_d = 1'b1;
          rdata_d  = reload_q;
        end
        A_STATUS: begin
          rvalid_d = 1'b1;
          rdata_d  = {{(timerwid-2){1'b0}},
                      state_q == S_RUN, expired_q};
        end
        A_COUNT: rd1_d = 1'b1;
        default: ;
      endcase
    end
    if (rd2_q) rdata_d = tmr_dataout;

    unique case (state_q)
      S_IDLE: if (ctrl_d[0]) state_d = S_LOAD;
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (!ctrl_d[0]) begin
          state_d = S_IDLE;
        end else if (evt && ctrl_d[1]) begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
      intr_q    <= 1'b0;
      irq_q     <= 1'b0;
      rd1_q     <= 1'b0;
      rd2_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
      intr_q    <= intr_d;
      irq_q     <= irq_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  // count data arrives straight from the timer in the valid cycle
  assign bus_rdata  = rd2_q ? tmr_dataout : rdata_q;
  assign bus_rvalid = rvalid_q | rd2_q;
  assign bus_busy   = rd1_q | rd2_q;
  assign irq        = irq_q;
  assign tmr_cs     = ~rst;
  assign tmr_wr     = (state_q == S_LOAD);
  assign tmr_start  = (state_q == S_RUN);
  assign tmr_rd     = rd1_q;
  assign tmr_datain = reload_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl; the timer side is driven by hand.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_cs = 1'b0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [15:0] bus_wdata = 16'h0;
  logic [15:0] bus_rdata;
  logic        bus_rvalid;
  logic        bus_busy;
  logic        irq;
  logic        tmr_cs;
  logic        tmr_wr;
  logic        tmr_start;
  logic        tmr_rd;
  logic [15:0] tmr_datain;
  logic        tmr_intrup = 1'b0;
  logic [15:0] tmr_dataout = 16'h0;

  int checks = 0;
  int errors = 0;

  timer_ctrl #(.timerwid(16)) dut (
    .clk(clk), .rst(rst),
    .bus_cs(bus_cs), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .bus_busy(bus_busy), .irq(irq),
    .tmr_cs(tmr_cs), .tmr_wr(tmr_wr), .tmr_start(tmr_start),
    .tmr_rd(tmr_rd), .tmr_datain(tmr_datain),
    .tmr_intrup(tmr_intrup), .tmr_dataout(tmr_dataout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bwrite(input logic [1:0] a, input logic [15:0] d);
    bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_wr = 1'b0;
  endtask

  task automatic bread(input logic [1:0] a);
    bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = a;
    tick();
    bus_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({bus_rdata, bus_rvalid, bus_busy, irq, tmr_cs, tmr_wr,
         tmr_start, tmr_rd, tmr_datain} !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h/%b%b%b%b%b%b%b/%h want all 0",
               bus_rdata, bus_rvalid, bus_busy, irq, tmr_cs, tmr_wr,
               tmr_start, tmr_rd, tmr_datain);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (tmr_cs !== 1'b1) begin
      errors++;
      $display("FAIL tmr_cs got %b want 1", tmr_cs);
    end
    bread(2'd2);
    checks++;
    if (bus_rvalid !== 1'b1 || bus_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_status got v=%b d=%h want v=1 d=0000",
               bus_rvalid, bus_rdata);
    end
    tick();
    checks++;
    if (bus_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_pulse got %b want 0", bus_rvalid);
    end
  endtask

  task automatic test_autoreload();
    bwrite(2'd1, 16'hFFF0);
    checks++;
    if (tmr_datain !== 16'hFFF0) begin
      errors++;
      $display("FAIL datain got %h want fff0", tmr_datain);
    end
    bwrite(2'd0, 16'h0005);
    checks++;
    if (tmr_wr !== 1'b1 || tmr_start !== 1'b0) begin
      errors++;
      $display("FAIL load_cycle got wr=%b st=%b want 1/0",
               tmr_wr, tmr_start);
    end
    tick();
    checks++;
    if (tmr_wr !== 1'b0 || tmr_start !== 1'b1) begin
      errors++;
      $display("FAIL run_cycle got wr=%b st=%b want 0/1",
               tmr_wr, tmr_start);
    end
    tmr_intrup = 1'b1;
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early got %b want 0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set got %b want 1", irq);
    end
    bread(2'd2);
    checks++;
    if (bus_rvalid !== 1'b1 || bus_rdata !== 16'h0003) begin
      errors++;
      $display("FAIL status_exp got v=%b d=%h want 1/0003",
               bus_rvalid, bus_rdata);
    end
    bwrite(2'd2, 16'h0001);
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear got %b want 0", irq);
    end
    bread(2'd2);
    checks++;
    if (bus_rdata !== 16'h0002) begin
      errors++;
      $display("FAIL held_level got %h want 0002", bus_rdata);
    end
    tmr_intrup = 1'b0;
    tick();
    tmr_intrup = 1'b1;
    tick(); tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_second got %b want 1", irq);
    end
    tmr_intrup = 1'b0;
    tick();
  endtask

  task automatic test_corners();
    bwrite(2'd1, 16'h1234);
    checks++;
    if (tmr_datain !== 16'h1234 || tmr_wr !== 1'b0) begin
      errors++;
      $display("FAIL reload_mid got %h wr=%b want 1234 wr=0",
               tmr_datain, tmr_wr);
    end
    tick();
    checks++;
    if (tmr_wr !== 1'b0 || tmr_start !== 1'b1) begin
      errors++;
      $display("FAIL reload_norestart got wr=%b st=%b want 0/1",
               tmr_wr, tmr_start);
    end
    bwrite(2'd2, 16'h0001);
    tmr_intrup = 1'b1;
    bwrite(2'd2, 16'h0001);
    bread(2'd2);
    checks++;
    if (bus_rdata !== 16'h0003) begin
      errors++;
      $display("FAIL w1c_race got %h want 0003", bus_rdata);
    end
    tmr_intrup = 1'b0;
    tick();
  endtask

  task automatic test_count_read();
    tmr_dataout = 16'hABCD;
    bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = 2'd3;
    tick();
    checks++;
    if (tmr_rd !== 1'b1 || bus_busy !== 1'b1 || bus_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cnt_n1 got rd=%b busy=%b v=%b want 1/1/0",
               tmr_rd, bus_busy, bus_rvalid);
    end
    tick();
    bus_rd = 1'b0;
    checks++;
    if (bus_rvalid !== 1'b1 || bus_rdata !== 16'hABCD ||
        bus_busy !== 1'b1 || tmr_rd !== 1'b0) begin
      errors++;
      $display("FAIL cnt_n2 got v=%b d=%h busy=%b rd=%b want 1/abcd/1/0",
               bus_rvalid, bus_rdata, bus_busy, tmr_rd);
    end
    tick();
    checks++;
    if (bus_rvalid !== 1'b0 || bus_busy !== 1'b0 ||
        bus_rdata !== 16'hABCD) begin
      errors++;
      $display("FAIL cnt_n3 got v=%b busy=%b d=%h want 0/0/abcd",
               bus_rvalid, bus_busy, bus_rdata);
    end
    tick();
    checks++;
    if (bus_rvalid !== 1'b0 || tmr_rd !== 1'b0) begin
      errors++;
      $display("FAIL cnt_extra got v=%b rd=%b want 0/0",
               bus_rvalid, tmr_rd);
    end
  endtask

  task automatic test_disable();
    bwrite(2'd0, 16'h0004);
    checks++;
    if (tmr_start !== 1'b0) begin
      errors++;
      $display("FAIL en_clear got %b want 0", tmr_start);
    end
  endtask

  task automatic test_oneshot();
    bwrite(2'd2, 16'h0001);
    bwrite(2'd1, 16'hFFFE);
    bwrite(2'd0, 16'h0003);
    tick();
    checks++;
    if (tmr_start !== 1'b1) begin
      errors++;
      $display("FAIL os_run got %b want 1", tmr_start);
    end
    tmr_intrup = 1'b1;
    tick();
    checks++;
    if (tmr_start !== 1'b0 || tmr_wr !== 1'b0) begin
      errors++;
      $display("FAIL os_idle got st=%b wr=%b want 0/0",
               tmr_start, tmr_wr);
    end
    bread(2'd0);
    checks++;
    if (bus_rdata !== 16'h0002) begin
      errors++;
      $display("FAIL os_ctrl got %h want 0002", bus_rdata);
    end
    bread(2'd2);
    checks++;
    if (bus_rdata !== 16'h0001) begin
      errors++;
      $display("FAIL os_status got %h want 0001", bus_rdata);
    end
    tmr_intrup = 1'b0;
    tick(); tick();
    checks++;
    if (tmr_start !== 1'b0) begin
      errors++;
      $display("FAIL os_stay got %b want 0", tmr_start);
    end
  endtask

  task automatic test_reset_midrun();
    bwrite(2'd2, 16'h0001);
    bwrite(2'd0, 16'h0005);
    tick();
    tmr_intrup = 1'b1;
    tick(); tick();
    tmr_intrup = 1'b0;
    checks++;
    if (irq !== 1'b1 || tmr_start !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got irq=%b st=%b want 1/1", irq, tmr_start);
    end
    bread(2'd3);
    rst = 1'b1;
    tick();
    checks++;
    if ({bus_rdata, bus_rvalid, bus_busy, irq, tmr_cs, tmr_wr,
         tmr_start, tmr_rd, tmr_datain} !== '0) begin
      errors++;
      $display("FAIL rst_mid got %h/%b%b%b%b%b%b%b/%h want all 0",
               bus_rdata, bus_rvalid, bus_busy, irq, tmr_cs, tmr_wr,
               tmr_start, tmr_rd, tmr_datain);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus_rvalid !== 1'b0 || tmr_start !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got v=%b st=%b irq=%b want 0/0/0",
               bus_rvalid, tmr_start, irq);
    end
  endtask

  initial begin
    test_reset();
    test_autoreload();
    test_corners();
    test_count_read();
    test_disable();
    test_oneshot();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Bus-side controller that configures and sequences one `timer` instance (16-bit up-counter that reloads from datain on wrap).
- Exposes four registers to the MCU core bus: CTRL, RELOAD, STATUS and COUNT.
- Drives the timer's cs/wr/start/rd/datain, converts expiry into a sticky status bit plus a maskable interrupt, and supports one-shot and auto-reload modes.

Parameters:
- timerwid, 16, width of timer count, RELOAD and bus data.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- bus_cs  input  1  block select; bus_wr/bus_rd are ignored when low.
- bus_wr  input  1  register write strobe, single cycle.
- bus_rd  input  1  register read request, single cycle.
- bus_addr  input  2  register index: 0 CTRL, 1 RELOAD, 2 STATUS, 3 COUNT.
- bus_wdata  input  timerwid  write data.
- bus_rdata  output  timerwid  read data, valid when bus_rvalid=1.
- bus_rvalid  output  1  one-cycle read-data-valid pulse.
- bus_busy  output  1  high while a read is pending; new bus_rd ignored.
- irq  output  1  interrupt to core: STATUS.expired & CTRL.irq_en, registered.
- tmr_cs  output  1  timer chip select.
- tmr_wr  output  1  timer load strobe.
- tmr_start  output  1  timer count enable.
- tmr_rd  output  1  timer read strobe.
- tmr_datain  output  timerwid  load/reload value to timer.
- tmr_intrup  input  1  timer expiry indication.
- tmr_dataout  input  timerwid  timer count, registered one cycle after tmr_rd.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; CTRL=0, RELOAD=0, STATUS.expired=0; FSM=IDLE; edge-detect register=0.
- After reset: tmr_cs=1 whenever rst=0.
- CTRL bits: [0] en, [1] oneshot, [2] irq_en; other bits read 0.
- RELOAD: full width, R/W.
- STATUS bits:
  - [0] expired: sticky, write-1-to-clear.
  - [1] running: read-only, 1 when FSM=RUN.
- COUNT: read-only; writes ignored.
- tmr_datain = RELOAD at all times. A RELOAD write during RUN takes effect at the next wrap; no restart.
- Expiry event: rising edge of tmr_intrup (registered copy, 0 then 1). Only the edge counts; a held-high level is not a new event.
- FSM states:
  - IDLE: tmr_start=0, tmr_wr=0. If CTRL.en=1, go to LOAD.
  - LOAD: exactly one cycle, tmr_wr=1, tmr_start=0. Go to RUN.
  - RUN: tmr_start=1, tmr_wr=0.
    - If CTRL.en=0, go to IDLE (the counter holds its value).
    - Else on an expiry event: if oneshot=1, clear CTRL.en and go to IDLE; if oneshot=0, stay in RUN (the timer auto-reloads).
- A CTRL write setting en=1 in cycle N: LOAD in N+1, RUN in N+2; the first count increment occurs at the N+3 edge.
- Expiry sets STATUS.expired in the cycle after the edge is detected. irq follows one cycle later.
- Simultaneous W1C of expired and a new expiry event in the same cycle: set wins, expired stays 1.
- Reads of CTRL, RELOAD or STATUS: bus_rdata/bus_rvalid valid one cycle after bus_rd.
- Reads of COUNT:
  - Cycle N: bus_rd, so tmr_rd=1 in N+1 (registered), bus_busy=1.
  - Timer dataout is valid after the N+1 edge; it is captured at N+2.
  - bus_rvalid=1 in N+2. bus_busy is high in N+1..N+2.
- bus_rd while busy: ignored, no rvalid generated. Simultaneous bus_wr and bus_rd: the write executes and the read is ignored.
- bus_rdata holds its last value when bus_rvalid=0.
- rst asserted mid-RUN or mid-read: next edge returns to IDLE, tmr_start=0, no pending rvalid. The timer's own count is not cleared.

Test Plan:
- Reset → check outputs and FSM: rst 2 cycles → all outputs 0; read STATUS → 0x0000 with rvalid exactly 1 cycle after rd.
- Auto-reload: RELOAD=0xFFF0, CTRL=0x0005 → tmr_wr pulse exactly one cycle, then tmr_start=1. Expiry edge → STATUS=0x0003, irq=1 two cycles after the edge. W1C 0x0001 → irq=0; a second expiry sets it again.
- One-shot: RELOAD=0xFFFE, CTRL=0x0003 → after one expiry, FSM returns to IDLE, CTRL reads 0x0002, tmr_start=0, STATUS=0x0001.
- COUNT read: timer running, bus_rd addr 3 at N → tmr_rd at N+1, bus_busy at N+1..N+2, rvalid at N+2 with tmr_dataout value. A second bus_rd at N+1 is ignored: only one rvalid.
- Corner cases:
  - W1C and expiry edge in the same cycle → expired remains 1.
  - CTRL.en cleared during RUN → tmr_start=0 next cycle.
  - RELOAD written mid-run → tmr_datain updates with no tmr_wr pulse.
- rst asserted during RUN with a COUNT read pending → no rvalid, all outputs 0 next cycle, irq=0.
